// File: rtl/wide_compare_sequencer.sv
// Wide magnitude/equality compare sequenced through one shared WIDTH-bit comparator, MS chunk first.
// Build option: define WCS_EARLY_EXIT_EN to leave COMPARE on the first unequal chunk.
module wide_compare_sequencer #(
    parameter int WIDTH  = 4,
    parameter int CHUNKS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH*CHUNKS-1:0]   x,
    input  logic [WIDTH*CHUNKS-1:0]   y,
    input  logic                      signed_unsigned,
    output logic                      busy,
    output logic                      done,
    output logic                      negative,
    output logic                      zero,
    output logic                      cout,
    output logic                      overflow,
    output logic [WIDTH-1:0]          cmp_x,
    output logic [WIDTH-1:0]          cmp_y,
    output logic                      cmp_signed,
    input  logic                      cmp_negative,
    input  logic                      cmp_zero
);

    localparam int TOTAL = WIDTH * CHUNKS;
    localparam int IDX_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMPARE,
        ST_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [TOTAL-1:0]   x_lat_reg, x_lat_next;
    logic [TOTAL-1:0]   y_lat_reg, y_lat_next;
    logic               signed_lat_reg, signed_lat_next;
    logic [IDX_W-1:0]   idx_reg, idx_next;
    logic               decided_reg, decided_next;
    logic               result_neg_reg, result_neg_next;
    logic               negative_reg, negative_next;
    logic               zero_reg, zero_next;
    logic               finish;

    logic [WIDTH-1:0]   x_chunk [CHUNKS];
    logic [WIDTH-1:0]   y_chunk [CHUNKS];

    genvar gi;
    generate
        for (gi = 0; gi < CHUNKS; gi++) begin : g_chunk
            assign x_chunk[gi] = x_lat_reg[gi*WIDTH +: WIDTH];
            assign y_chunk[gi] = y_lat_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            x_lat_reg      <= '0;
            y_lat_reg      <= '0;
            signed_lat_reg <= 1'b0;
            idx_reg        <= '0;
            decided_reg    <= 1'b0;
            result_neg_reg <= 1'b0;
            negative_reg   <= 1'b0;
            zero_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_lat_reg      <= x_lat_next;
            y_lat_reg      <= y_lat_next;
            signed_lat_reg <= signed_lat_next;
            idx_reg        <= idx_next;
            decided_reg    <= decided_next;
            result_neg_reg <= result_neg_next;
            negative_reg   <= negative_next;
            zero_reg       <= zero_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        x_lat_next      = x_lat_reg;
        y_lat_next      = y_lat_reg;
        signed_lat_next = signed_lat_reg;
        idx_next        = idx_reg;
        decided_next    = decided_reg;
        result_neg_next = result_neg_reg;
        negative_next   = negative_reg;
        zero_next       = zero_reg;
        busy            = 1'b0;
        done            = 1'b0;
        cmp_x           = '0;
        cmp_y           = '0;
        cmp_signed      = 1'b0;
        finish          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    x_lat_next      = x;
                    y_lat_next      = y;
                    signed_lat_next = signed_unsigned;
                    idx_next        = LAST_IDX;
                    decided_next    = 1'b0;
                    result_neg_next = 1'b0;
                    state_next      = ST_COMPARE;
                end
            end

            ST_COMPARE: begin
                busy       = 1'b1;
                cmp_x      = x_chunk[idx_reg];
                cmp_y      = y_chunk[idx_reg];
                // Only the top chunk holds the sign bit; lower chunks are plain magnitudes.
                cmp_signed = signed_lat_reg && (idx_reg == LAST_IDX);

                if (!decided_reg && !cmp_zero) begin
                    decided_next    = 1'b1;
                    result_neg_next = cmp_negative;
                end

`ifdef WCS_EARLY_EXIT_EN
                finish = (idx_reg == '0) || !cmp_zero;
`else
                finish = (idx_reg == '0);
`endif

                if (finish) begin
                    state_next    = ST_DONE;
                    // Fold in this cycle's comparator result so flags are ready in the DONE cycle.
                    negative_next = decided_reg ? result_neg_reg : (!cmp_zero && cmp_negative);
                    zero_next     = !decided_reg && cmp_zero;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end

            ST_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign negative = negative_reg;
    assign zero     = zero_reg;
    assign cout     = 1'b0;
    assign overflow = 1'b0;

endmodule

// File: doc/wide_compare_sequencer.md
Name: wide_compare_sequencer

Overview:
Multi-cycle controller that compares two wide operands (WIDTH*CHUNKS bits) through one shared WIDTH-bit comparator, one chunk per cycle, most significant chunk first. It drives the comparator's x/y/signed_unsigned inputs and reads its negative/zero flags. It produces CPSR-style flags (negative, zero, cout, overflow) for wide compare instructions in the ALU. A start/busy/done handshake sequences it.

Parameters:
WIDTH, 4, chunk width; must match the attached comparator's WIDTH.
CHUNKS, 4, number of chunks per operand; must be >= 2. Total operand width is WIDTH*CHUNKS.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  request a compare; accepted only in IDLE.
x  input  WIDTH*CHUNKS  operand A; sampled on the accepting edge.
y  input  WIDTH*CHUNKS  operand B; sampled on the accepting edge.
signed_unsigned  input  1  1 = signed (two's complement) compare, 0 = unsigned; sampled with operands.
busy  output  1  high from the accept edge until the FSM returns to IDLE.
done  output  1  one-cycle pulse; flags are valid from this cycle.
negative  output  1  1 when x < y under the selected signedness.
zero  output  1  1 when x == y.
cout  output  1  constant 0.
overflow  output  1  constant 0.
cmp_x  output  WIDTH  chunk of latched x driven to the comparator.
cmp_y  output  WIDTH  chunk of latched y driven to the comparator.
cmp_signed  output  1  signedness driven to the comparator.
cmp_negative  input  1  comparator lt flag, combinational from cmp_*.
cmp_zero  input  1  comparator eq flag, combinational from cmp_*.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, busy=0, done=0, negative=0, zero=0.
  - Latched operands and index cleared.
  - Applies at any time, including mid-compare; the in-flight compare is discarded and no done pulse is produced.
- FSM states: IDLE, COMPARE, DONE.
- IDLE:
  - cmp_* outputs driven to 0.
  - On start=1: latch x, y, signed_unsigned; set idx=CHUNKS-1; go to COMPARE.
- COMPARE, one chunk per cycle:
  - cmp_x = x_lat[idx*WIDTH +: WIDTH]; cmp_y likewise from y_lat.
  - cmp_signed = signed_lat AND (idx==CHUNKS-1). Only the top chunk carries the sign; lower chunks always compare unsigned.
  - cmp_negative and cmp_zero are sampled on the same edge.
  - If cmp_zero=0 and the result is not yet decided: record result_neg=cmp_negative.
  - If idx==0, or early exit applies (see Optional Feature): go to DONE.
  - Otherwise decrement idx.
- DONE (exactly one cycle):
  - done=1.
  - negative=result_neg; zero=1 only if every chunk compared equal.
  - Next state IDLE.
- Handshake and output timing:
  - busy=1 in COMPARE and DONE.
  - start is ignored while busy, including in the DONE cycle.
  - negative and zero are registered, update only on entry to DONE, and hold until the next DONE or reset.
- Latency: done rises k+1 cycles after the accept edge, where k = number of COMPARE cycles executed.
- Minimum issue interval: start may be accepted on the first IDLE cycle after DONE.
- cout and overflow are tied to 0, matching the comparator's CPSR convention.

Optional Feature:
WCS_EARLY_EXIT_EN
- Defined: COMPARE exits to DONE on the first chunk with cmp_zero=0. k ranges from 1 to CHUNKS.
- Undefined: COMPARE always runs all CHUNKS cycles, giving constant latency CHUNKS+1. Only the first differing chunk (most significant) determines result_neg; later chunks cannot overwrite it.
- Flag results are identical in both builds.

Test Plan:
- WIDTH=4, CHUNKS=4, unsigned, x=0x8000, y=0x7FFF -> negative=0, zero=0. done at accept+2 with WCS_EARLY_EXIT_EN, accept+5 without.
- Signed, x=0x8000, y=0x7FFF -> negative=1, zero=0. cmp_signed=1 only in the first COMPARE cycle.
- Unsigned, x=y=0x1234 -> negative=0, zero=1; done at accept+5 in both builds; cout=overflow=0.
- Signed, x=0xFFF0, y=0xFFF1 (differ in lowest chunk only) -> negative=1, zero=0; done at accept+5.
- Start pulsed during COMPARE and again during DONE with different operands -> both ignored; flags reflect the first request only; a new start in the following IDLE cycle is accepted.
- rst_n driven low during the second COMPARE cycle -> busy, done, negative and zero go 0 immediately; no done pulse after release; a subsequent compare of 0x0001 vs 0x0002 (unsigned) gives negative=1.
